// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - MIPS opcode/funct constants, ALU encodings and the ID/EX bundle type
package decode_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // All-zero word doubles as the pipeline bubble
  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_LUI = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rd_dest;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] pc_plus4;
  } id_ex_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0, v};
  endfunction

endpackage

// File: rtl/decode_if.sv
// rtl/decode_if.sv - fetch/writeback inputs and ID/EX outputs of the decode stage
interface decode_if;
  logic [31:0] instruction;
  logic [31:0] PCnext;
  logic        stall;
  logic        wbEn;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        PCsrc;
  logic [31:0] brnchJmpAddr;
  logic        idValid;
  logic        illegal;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [31:0] imm;
  logic [4:0]  rdDest;
  logic [3:0]  aluOp;
  logic        aluSrc;
  logic        memRead;
  logic        memWrite;
  logic        regWrite;
  logic        memToReg;
  logic [31:0] PCplus4;

  // Surrounding pipeline: feeds instructions and writebacks, consumes the bundle
  modport master (
    output instruction, PCnext, stall, wbEn, wbAddr, wbData,
    input  PCsrc, brnchJmpAddr, idValid, illegal, rsData, rtData, imm, rdDest,
           aluOp, aluSrc, memRead, memWrite, regWrite, memToReg, PCplus4
  );

  // Decode stage itself
  modport slave (
    input  instruction, PCnext, stall, wbEn, wbAddr, wbData,
    output PCsrc, brnchJmpAddr, idValid, illegal, rsData, rtData, imm, rdDest,
           aluOp, aluSrc, memRead, memWrite, regWrite, memToReg, PCplus4
  );
endinterface

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 32x32 register file, two bypassed read ports, one write port
module decode_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];

  // Clear on reset; $0 is never written so it stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads forward a same-cycle write so decode never sees a stale operand
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    if (we && waddr == raddr_a) rdata_a = wdata;
    if (we && waddr == raddr_b) rdata_b = wdata;
    if (raddr_a == 5'd0) rdata_a = '0;
    if (raddr_b == 5'd0) rdata_b = '0;
  end

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - MIPS decode stage: IF/ID latch, control decode, branch/jump redirect, ID/EX latch
module decode
  import decode_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);

  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        redirect;
  logic [31:0] target;
  logic        i_alu;
  id_ex_t      dec;
  id_ex_t      id_ex_q;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;

  assign op    = instr_q[31:26];
  assign rs    = instr_q[25:21];
  assign rt    = instr_q[20:16];
  assign rd    = instr_q[15:11];
  assign shamt = instr_q[10:6];
  assign funct = instr_q[5:0];
  assign imm16 = instr_q[15:0];

  decode_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_val),
    .rdata_b (rt_val),
    .we      (bus.wbEn),
    .waddr   (bus.wbAddr),
    .wdata   (bus.wbData)
  );

  // IF/ID latch: stall holds, a taken redirect squashes the wrong-path word
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP;
      pc4_q   <= '0;
    end else if (!bus.stall) begin
      if (redirect) begin
        instr_q <= NOP;
        pc4_q   <= '0;
      end else begin
        instr_q <= bus.instruction;
        pc4_q   <= bus.PCnext;
      end
    end
  end

  // Control decode of the word in IF/ID into an ID/EX bundle
  always_comb begin
    dec          = '0;
    i_alu        = 1'b0;
    dec.valid    = 1'b1;
    dec.rs_data  = rs_val;
    dec.rt_data  = rt_val;
    dec.pc_plus4 = pc4_q;
    case (op)
      OP_RTYPE: begin
        dec.rd_dest   = rd;
        dec.reg_write = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
          FN_AND:          dec.alu_op = ALU_AND;
          FN_OR:           dec.alu_op = ALU_OR;
          FN_XOR:          dec.alu_op = ALU_XOR;
          FN_NOR:          dec.alu_op = ALU_NOR;
          FN_SLT:          dec.alu_op = ALU_SLT;
          FN_SLL, FN_SRL: begin
            dec.alu_op  = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
            dec.imm     = {27'd0, shamt};
            dec.alu_src = 1'b1;
          end
          default: begin
            // JR is resolved by the redirect path; anything else is unsupported
            dec.rd_dest   = '0;
            dec.reg_write = 1'b0;
            dec.illegal   = (funct != FN_JR);
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin dec.alu_op = ALU_ADD; dec.imm = sext16(imm16); i_alu = 1'b1; end
      OP_SLTI:           begin dec.alu_op = ALU_SLT; dec.imm = sext16(imm16); i_alu = 1'b1; end
      OP_ANDI:           begin dec.alu_op = ALU_AND; dec.imm = zext16(imm16); i_alu = 1'b1; end
      OP_ORI:            begin dec.alu_op = ALU_OR;  dec.imm = zext16(imm16); i_alu = 1'b1; end
      OP_XORI:           begin dec.alu_op = ALU_XOR; dec.imm = zext16(imm16); i_alu = 1'b1; end
      OP_LUI:            begin dec.alu_op = ALU_LUI; dec.imm = zext16(imm16); i_alu = 1'b1; end
      OP_LW: begin
        dec.alu_op     = ALU_ADD;
        dec.imm        = sext16(imm16);
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.rd_dest    = rt;
      end
      OP_SW: begin
        dec.alu_op    = ALU_ADD;
        dec.imm       = sext16(imm16);
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_J: ;
      default: dec.illegal = 1'b1;
    endcase
    if (i_alu) begin
      dec.rd_dest   = rt;
      dec.alu_src   = 1'b1;
      dec.reg_write = 1'b1;
    end
  end

  // Branch/jump resolution; suppressed while stalled so the branch resolves on release
  always_comb begin
    redirect = 1'b0;
    target   = '0;
    if (!rst && !bus.stall) begin
      case (op)
        OP_BEQ: if (rs_val == rt_val) begin
          redirect = 1'b1;
          target   = pc4_q + {{14{imm16[15]}}, imm16, 2'b00};
        end
        OP_BNE: if (rs_val != rt_val) begin
          redirect = 1'b1;
          target   = pc4_q + {{14{imm16[15]}}, imm16, 2'b00};
        end
        OP_J: begin
          redirect = 1'b1;
          target   = {pc4_q[31:28], instr_q[25:0], 2'b00};
        end
        OP_RTYPE: if (funct == FN_JR) begin
          redirect = 1'b1;
          target   = rs_val;
        end
        default: ;
      endcase
    end
  end

  // ID/EX latch: bubble on stall or an empty IF/ID
  always_ff @(posedge clk) begin
    if (rst || bus.stall || instr_q == NOP) id_ex_q <= '0;
    else                                    id_ex_q <= dec;
  end

  assign bus.PCsrc        = redirect;
  assign bus.brnchJmpAddr = target;
  assign bus.idValid      = id_ex_q.valid;
  assign bus.illegal      = id_ex_q.illegal;
  assign bus.rsData       = id_ex_q.rs_data;
  assign bus.rtData       = id_ex_q.rt_data;
  assign bus.imm          = id_ex_q.imm;
  assign bus.rdDest       = id_ex_q.rd_dest;
  assign bus.aluOp        = id_ex_q.alu_op;
  assign bus.aluSrc       = id_ex_q.alu_src;
  assign bus.memRead      = id_ex_q.mem_read;
  assign bus.memWrite     = id_ex_q.mem_write;
  assign bus.regWrite     = id_ex_q.reg_write;
  assign bus.memToReg     = id_ex_q.mem_to_reg;
  assign bus.PCplus4      = id_ex_q.pc_plus4;

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - randomized and directed checks of decode against a table-driven reference
module tb_decode;

  typedef struct packed {
    bit   is_r;
    logic [5:0] code;
    logic [3:0] alu;
    int   ext;   // 0 none, 1 signed imm16, 2 unsigned imm16, 3 shamt
    int   dst;   // 0 none, 1 rd, 2 rt
    bit   src, mr, mw, rw, m2r;
  } row_t;

  typedef struct packed {
    bit   valid, illegal;
    logic [31:0] rs, rt, imm;
    logic [4:0]  dest;
    logic [3:0]  alu;
    bit   src, mr, mw, rw, m2r;
    logic [31:0] pc4;
  } bundle_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_if bus();
  decode dut (.clk(clk), .rst(rst), .bus(bus));

  row_t        tbl[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_instr, m_pc4;
  bundle_t     e;
  logic        e_pcsrc;
  logic [31:0] e_target;
  bit          model_ok = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic row_t mk(bit is_r, logic [5:0] code, logic [3:0] alu, int ext, int dst,
                              bit src, bit mr, bit mw, bit rw, bit m2r);
    row_t r;
    r.is_r = is_r; r.code = code; r.alu = alu; r.ext = ext; r.dst = dst;
    r.src = src; r.mr = mr; r.mw = mw; r.rw = rw; r.m2r = m2r;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Register value as decode must see it, including a same-cycle writeback
  function automatic logic [31:0] rd_reg(logic [4:0] i);
    if (i == 5'd0) return 32'h0;
    if (bus.wbEn && bus.wbAddr == i) return bus.wbData;
    return m_regs[i];
  endfunction

  function automatic logic [31:0] sx(logic [31:0] ins);
    return ins[15] ? ({16'h0, ins[15:0]} - 32'h0001_0000) : {16'h0, ins[15:0]};
  endfunction

  function automatic bundle_t ref_decode(logic [31:0] ins, logic [31:0] pc4);
    bundle_t b;
    int idx;
    row_t r;
    bit rtype;
    b = '0;
    b.valid = 1;
    b.rs = rd_reg(ins[25:21]);
    b.rt = rd_reg(ins[20:16]);
    b.pc4 = pc4;
    rtype = (ins[31:26] == 6'h00);
    idx = -1;
    foreach (tbl[k])
      if (tbl[k].is_r == rtype && tbl[k].code == (rtype ? ins[5:0] : ins[31:26])) idx = k;
    if (idx < 0) begin
      b.illegal = 1;
      return b;
    end
    r = tbl[idx];
    b.alu = r.alu;
    b.src = r.src; b.mr = r.mr; b.mw = r.mw; b.rw = r.rw; b.m2r = r.m2r;
    case (r.ext)
      1: b.imm = sx(ins);
      2: b.imm = ins & 32'h0000_FFFF;
      3: b.imm = (ins >> 6) & 32'd31;
      default: b.imm = 32'h0;
    endcase
    case (r.dst)
      1: b.dest = ins[15:11];
      2: b.dest = ins[20:16];
      default: b.dest = 5'd0;
    endcase
    return b;
  endfunction

  // Expected redirect for the current IF/ID contents and current inputs
  task automatic model_comb();
    logic [5:0] op;
    e_pcsrc = 0;
    e_target = 32'h0;
    op = m_instr[31:26];
    if (!rst && !bus.stall) begin
      if ((op == 6'h04 && rd_reg(m_instr[25:21]) == rd_reg(m_instr[20:16])) ||
          (op == 6'h05 && rd_reg(m_instr[25:21]) != rd_reg(m_instr[20:16]))) begin
        e_pcsrc = 1;
        e_target = m_pc4 + sx(m_instr) * 32'd4;
      end else if (op == 6'h02) begin
        e_pcsrc = 1;
        e_target = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 32'd4);
      end else if (op == 6'h00 && m_instr[5:0] == 6'h08) begin
        e_pcsrc = 1;
        e_target = rd_reg(m_instr[25:21]);
      end
    end
  endtask

  // Advance the model across one rising edge using the inputs of the ending cycle
  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_instr = 32'h0;
      m_pc4 = 32'h0;
      e = '0;
    end else begin
      e = (bus.stall || m_instr == 32'h0) ? '0 : ref_decode(m_instr, m_pc4);
      if (!bus.stall) begin
        m_instr = e_pcsrc ? 32'h0 : bus.instruction;
        m_pc4   = e_pcsrc ? 32'h0 : bus.PCnext;
      end
      if (bus.wbEn && bus.wbAddr != 5'd0) m_regs[bus.wbAddr] = bus.wbData;
    end
    model_ok = 1;
  endtask

  task automatic cycle(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                       input logic st, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    @(posedge clk);
    model_step();
    #1;
    rst = r;
    bus.instruction = ins;
    bus.PCnext = pc;
    bus.stall = st;
    bus.wbEn = we;
    bus.wbAddr = wa;
    bus.wbData = wd;
    model_comb();
    #1;
  endtask

  task automatic idle();
    cycle(0, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    row_t r;
    w = $urandom;
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) w[20:16] = w[25:21];
    k = $urandom_range(0, 9);
    if (k == 0) return 32'h0;
    if (k > 1) begin
      r = tbl[$urandom_range(0, tbl.size() - 1)];
      if (r.is_r) begin
        w[31:26] = 6'h00;
        w[5:0] = r.code;
      end else begin
        w[31:26] = r.code;
      end
    end
    return w;
  endfunction

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (model_ok) begin
      chk("PCsrc",        32'(bus.PCsrc),    32'(e_pcsrc));
      chk("brnchJmpAddr", bus.brnchJmpAddr,  e_target);
      chk("idValid",      32'(bus.idValid),  32'(e.valid));
      chk("illegal",      32'(bus.illegal),  32'(e.illegal));
      chk("rsData",       bus.rsData,        e.rs);
      chk("rtData",       bus.rtData,        e.rt);
      chk("imm",          bus.imm,           e.imm);
      chk("rdDest",       32'(bus.rdDest),   32'(e.dest));
      chk("aluOp",        32'(bus.aluOp),    32'(e.alu));
      chk("aluSrc",       32'(bus.aluSrc),   32'(e.src));
      chk("memRead",      32'(bus.memRead),  32'(e.mr));
      chk("memWrite",     32'(bus.memWrite), 32'(e.mw));
      chk("regWrite",     32'(bus.regWrite), 32'(e.rw));
      chk("memToReg",     32'(bus.memToReg), 32'(e.m2r));
      chk("PCplus4",      bus.PCplus4,       e.pc4);
    end
  end

  initial begin
    logic [31:0] pcr;
    rst = 1;
    bus.instruction = 32'h0; bus.PCnext = 32'h0; bus.stall = 0;
    bus.wbEn = 0; bus.wbAddr = 5'd0; bus.wbData = 32'h0;

    //            is_r code   alu   ext dst src mr mw rw m2r
    tbl.push_back(mk(1, 6'h20, 4'd0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h21, 4'd0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h22, 4'd1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h23, 4'd1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h24, 4'd2, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h25, 4'd3, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h26, 4'd4, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h27, 4'd5, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h2A, 4'd6, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h00, 4'd7, 3, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h02, 4'd8, 3, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h08, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h08, 4'd0, 1, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 6'h09, 4'd0, 1, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 6'h0A, 4'd6, 1, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 6'h0C, 4'd2, 2, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 6'h0D, 4'd3, 2, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 6'h0E, 4'd4, 2, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 6'h0F, 4'd9, 2, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 6'h23, 4'd0, 1, 2, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 6'h2B, 4'd0, 1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 6'h04, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h05, 4'd0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h02, 4'd0, 0, 0, 0, 0, 0, 0, 0));

    // Reset with a live instruction on the input
    cycle(1, 32'h2002_0005, 32'h8, 0, 0, 5'd0, 32'h0);
    idle();
    chk("rst.idValid", 32'(bus.idValid), 32'h0);
    chk("rst.PCsrc", 32'(bus.PCsrc), 32'h0);
    chk("rst.rsData", bus.rsData, 32'h0);
    chk("rst.regWrite", 32'(bus.regWrite), 32'h0);
    chk("rst.PCplus4", bus.PCplus4, 32'h0);

    // ADDI $2,$1,-3 with $1=7
    cycle(0, 32'h0, 32'h0, 0, 1, 5'd1, 32'd7);
    cycle(0, 32'h2022_FFFD, 32'h44, 0, 0, 5'd0, 32'h0);
    idle();
    idle();
    chk("addi.idValid", 32'(bus.idValid), 32'h1);
    chk("addi.rsData", bus.rsData, 32'd7);
    chk("addi.imm", bus.imm, 32'hFFFF_FFFD);
    chk("addi.aluOp", 32'(bus.aluOp), 32'd0);
    chk("addi.aluSrc", 32'(bus.aluSrc), 32'h1);
    chk("addi.regWrite", 32'(bus.regWrite), 32'h1);
    chk("addi.rdDest", 32'(bus.rdDest), 32'd2);

    // BEQ $3,$4,+4 taken, following word flushed
    cycle(0, 32'h0, 32'h0, 0, 1, 5'd3, 32'd9);
    cycle(0, 32'h0, 32'h0, 0, 1, 5'd4, 32'd9);
    cycle(0, 32'h1064_0004, 32'h100, 0, 0, 5'd0, 32'h0);
    cycle(0, 32'h2003_0001, 32'h104, 0, 0, 5'd0, 32'h0);
    chk("beq.PCsrc", 32'(bus.PCsrc), 32'h1);
    chk("beq.target", bus.brnchJmpAddr, 32'h110);
    idle();
    chk("beq.issued", 32'(bus.idValid), 32'h1);
    chk("beq.regWrite", 32'(bus.regWrite), 32'h0);
    idle();
    chk("beq.flushed", 32'(bus.idValid), 32'h0);

    // Writeback bypass, and $0 stays zero
    cycle(0, 32'h00A0_3020, 32'h200, 0, 0, 5'd0, 32'h0);
    cycle(0, 32'h0, 32'h0, 0, 1, 5'd5, 32'hDEAD_BEEF);
    idle();
    chk("bypass.rsData", bus.rsData, 32'hDEAD_BEEF);
    cycle(0, 32'h0000_3820, 32'h204, 0, 0, 5'd0, 32'h0);
    cycle(0, 32'h0, 32'h0, 0, 1, 5'd0, 32'h1234_5678);
    idle();
    chk("r0.rsData", bus.rsData, 32'h0);
    chk("r0.rtData", bus.rtData, 32'h0);

    // J held by a 3-cycle stall, resolves on release
    cycle(0, 32'h0840_0000, 32'h3000_0040, 0, 0, 5'd0, 32'h0);
    for (int s = 0; s < 3; s++) begin
      cycle(0, 32'h2004_0001, 32'h3000_0044, 1, 0, 5'd0, 32'h0);
      chk("stall.PCsrc", 32'(bus.PCsrc), 32'h0);
      if (s > 0) chk("stall.bubble", 32'(bus.idValid), 32'h0);
    end
    cycle(0, 32'h2004_0001, 32'h3000_0044, 0, 0, 5'd0, 32'h0);
    chk("jrel.bubble", 32'(bus.idValid), 32'h0);
    chk("jrel.PCsrc", 32'(bus.PCsrc), 32'h1);
    chk("jrel.target", bus.brnchJmpAddr, 32'h3100_0000);
    idle();
    chk("j.issued", 32'(bus.idValid), 32'h1);

    // Unsupported opcode 0x3F
    cycle(0, 32'hFC00_0000, 32'h500, 0, 0, 5'd0, 32'h0);
    idle();
    idle();
    chk("ill.idValid", 32'(bus.idValid), 32'h1);
    chk("ill.illegal", 32'(bus.illegal), 32'h1);
    chk("ill.regWrite", 32'(bus.regWrite), 32'h0);
    chk("ill.aluSrc", 32'(bus.aluSrc), 32'h0);
    chk("ill.memRead", 32'(bus.memRead), 32'h0);
    chk("ill.memWrite", 32'(bus.memWrite), 32'h0);

    // Randomized traffic with occasional stalls and resets
    for (int n = 0; n < 3000; n++) begin
      pcr = $urandom;
      pcr[1:0] = 2'b00;
      cycle(($urandom_range(0, 99) == 0), rand_instr(), pcr, ($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end
    idle();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
